mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/mc_ctrl_if.sv | 40 ++++
 rtl/mc_ctrl_decode.sv | 46 ++++
 rtl/mc_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types, encodings and opcode tables for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

  localparam int unsigned StateW = 4;
  localparam int unsigned AluW   = 5;

  typedef enum logic [StateW-1:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWr   = 4'd6,
    StWbAlu   = 4'd7,
    StWbMem   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10
  } state_e;

  // Instruction class latched at DECODE; drives every later-state decision.
  typedef enum logic [3:0] {
    ClsIllegal, ClsRArith, ClsRShift, ClsIArith, ClsLw, ClsSw,
    ClsBeq, ClsBne, ClsJ, ClsJal, ClsJr
  } cls_e;

  // PC source
  localparam logic [1:0] PcNew = 2'd0, PcBranch = 2'd1, PcJump = 2'd2, PcJr = 2'd3;
  // Destination register
  localparam logic [1:0] DstRt = 2'd0, DstRd = 2'd1, DstRa = 2'd2;
  // Writeback source
  localparam logic [1:0] D2rAlu = 2'd0, D2rMem = 2'd1, D2rPc = 2'd2;
  // ALU operand selects
  localparam logic [1:0] SrcAPc = 2'd0, SrcARs = 2'd1, SrcAShamt = 2'd2;
  localparam logic [1:0] SrcBRt = 2'd0, SrcBFour = 2'd1, SrcBImm = 2'd2, SrcBImmSh2 = 2'd3;
  // Immediate extension
  localparam logic ExtZero = 1'b0, ExtSign = 1'b1;

  // ALU operations
  localparam logic [AluW-1:0] AluNop = 5'd0,  AluAdd = 5'd1,  AluSub = 5'd2,  AluAddu = 5'd3;
  localparam logic [AluW-1:0] AluSubu = 5'd4, AluAnd = 5'd5,  AluOr = 5'd6,   AluSlt = 5'd7;
  localparam logic [AluW-1:0] AluSll = 5'd8,  AluSrl = 5'd9,  AluSra = 5'd10, AluLui = 5'd11;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04;
  localparam logic [5:0] OpBne = 6'h05, OpAddi = 6'h08, OpSlti = 6'h0a, OpAndi = 6'h0c;
  localparam logic [5:0] OpOri = 6'h0d, OpLui = 6'h0f, OpLw = 6'h23, OpSw = 6'h2b;

  // R-type function codes
  localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnSra = 6'h03, FnJr = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20, FnAddu = 6'h21, FnSub = 6'h22, FnSubu = 6'h23;
  localparam logic [5:0] FnAnd = 6'h24, FnOr = 6'h25, FnSlt = 6'h2a;

  typedef struct packed {
    cls_e            cls;
    logic [AluW-1:0] aluop;
    logic            extop;
  } dec_t;

  function automatic dec_t mk_dec(input cls_e cls, input logic [AluW-1:0] aluop,
                                  input logic extop);
    dec_t d;
    d.cls   = cls;
    d.aluop = aluop;
    d.extop = extop;
    return d;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the shared datapath.
interface mc_ctrl_if #(
  parameter int unsigned ALUOP_W = 5
);
  import mc_ctrl_pkg::*;

  logic [5:0]         opcode;
  logic [5:0]         func;
  logic               zero;
  logic               mem_ready;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               PCWrite;
  logic [1:0]         PC_sel;
  logic [1:0]         RegDst;
  logic               RegWrite;
  logic [1:0]         DatatoReg;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               ExtOp;
  logic [ALUOP_W-1:0] ALUCtrl;
  logic [StateW-1:0]  state;
  logic               illegal;
  logic               bus_err;

  modport master (
    input  opcode, func, zero, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, PCWrite, PC_sel, RegDst, RegWrite,
           DatatoReg, ALUSrcA, ALUSrcB, ExtOp, ALUCtrl, state, illegal, bus_err
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, PCWrite, PC_sel, RegDst, RegWrite,
           DatatoReg, ALUSrcA, ALUSrcB, ExtOp, ALUCtrl, state, illegal, bus_err
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/func decode into instruction class, ALU op and extension mode.
module mc_ctrl_decode import mc_ctrl_pkg::*; (
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output dec_t       dec,
  output logic       illegal
);

  // Table lookup; anything unlisted falls through as illegal.
  always_comb begin
    dec = mk_dec(ClsIllegal, AluNop, ExtZero);
    unique case (opcode)
      OpRtype: begin
        unique case (func)
          FnAdd:   dec = mk_dec(ClsRArith, AluAdd,  ExtZero);
          FnAddu:  dec = mk_dec(ClsRArith, AluAddu, ExtZero);
          FnSub:   dec = mk_dec(ClsRArith, AluSub,  ExtZero);
          FnSubu:  dec = mk_dec(ClsRArith, AluSubu, ExtZero);
          FnAnd:   dec = mk_dec(ClsRArith, AluAnd,  ExtZero);
          FnOr:    dec = mk_dec(ClsRArith, AluOr,   ExtZero);
          FnSlt:   dec = mk_dec(ClsRArith, AluSlt,  ExtZero);
          FnSll:   dec = mk_dec(ClsRShift, AluSll,  ExtZero);
          FnSrl:   dec = mk_dec(ClsRShift, AluSrl,  ExtZero);
          FnSra:   dec = mk_dec(ClsRShift, AluSra,  ExtZero);
          FnJr:    dec = mk_dec(ClsJr,     AluNop,  ExtZero);
          default: dec = mk_dec(ClsIllegal, AluNop, ExtZero);
        endcase
      end
      OpJ:     dec = mk_dec(ClsJ,      AluNop, ExtZero);
      OpJal:   dec = mk_dec(ClsJal,    AluNop, ExtZero);
      OpBeq:   dec = mk_dec(ClsBeq,    AluSub, ExtSign);
      OpBne:   dec = mk_dec(ClsBne,    AluSub, ExtSign);
      OpAddi:  dec = mk_dec(ClsIArith, AluAdd, ExtSign);
      OpSlti:  dec = mk_dec(ClsIArith, AluSlt, ExtSign);
      OpAndi:  dec = mk_dec(ClsIArith, AluAnd, ExtZero);
      OpOri:   dec = mk_dec(ClsIArith, AluOr,  ExtZero);
      OpLui:   dec = mk_dec(ClsIArith, AluLui, ExtZero);
      OpLw:    dec = mk_dec(ClsLw,     AluAdd, ExtSign);
      OpSw:    dec = mk_dec(ClsSw,     AluAdd, ExtSign);
      default: dec = mk_dec(ClsIllegal, AluNop, ExtZero);
    endcase
  end

  assign illegal = (dec.cls == ClsIllegal);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: FSM, latched instruction class and memory timeout counter.
module mc_ctrl import mc_ctrl_pkg::*; #(
  parameter int unsigned ALUOP_W     = 5,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rstn,
  mc_ctrl_if.master  bus
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e          state_q;
  dec_t            dec;
  dec_t            dec_q;
  logic            dec_illegal;
  logic [CntW-1:0] cnt_q;
  logic            run_q;
  logic            mem_state;
  logic            timed_out;

  mc_ctrl_decode u_decode (
    .opcode  (bus.opcode),
    .func    (bus.func),
    .dec     (dec),
    .illegal (dec_illegal)
  );

  // run_q keeps every strobe quiet until the first edge after reset release.
  assign mem_state = run_q && (state_q inside {StFetch, StMemRd, StMemWr});
  // The limit is the count after MEM_TIMEOUT wait cycles; a same-cycle mem_ready still wins.
  assign timed_out = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready &&
                     (cnt_q == CntW'(MEM_TIMEOUT));

  // State sequencing, class latch and wait counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StFetch;
      dec_q   <= mk_dec(ClsIllegal, AluNop, ExtZero);
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      // Counter only runs while a request is left waiting; any state change clears it.
      if ((MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready && !timed_out) begin
        cnt_q <= cnt_q + CntW'(1);
      end else begin
        cnt_q <= '0;
      end
      unique case (state_q)
        StFetch: begin
          if (bus.mem_ready) state_q <= StDecode;
        end
        StDecode: begin
          dec_q <= dec;
          unique case (dec.cls)
            ClsRArith, ClsRShift:  state_q <= StExecR;
            ClsIArith:             state_q <= StExecI;
            ClsLw, ClsSw:          state_q <= StMemAddr;
            ClsBeq, ClsBne:        state_q <= StBranch;
            ClsJ, ClsJal, ClsJr:   state_q <= StJump;
            default:               state_q <= StFetch;
          endcase
        end
        StExecR, StExecI: state_q <= StWbAlu;
        StMemAddr: state_q <= (dec_q.cls == ClsSw) ? StMemWr : StMemRd;
        StMemRd: begin
          if (bus.mem_ready)  state_q <= StWbMem;
          else if (timed_out) state_q <= StFetch;
        end
        StMemWr: begin
          if (bus.mem_ready || timed_out) state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  // Output decode from state and latched class; FETCH/BRANCH PCWrite are Mealy.
  always_comb begin
    bus.IorD      = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.PC_sel    = PcNew;
    bus.RegDst    = DstRt;
    bus.RegWrite  = 1'b0;
    bus.DatatoReg = D2rAlu;
    bus.ALUSrcA   = SrcAPc;
    bus.ALUSrcB   = SrcBRt;
    bus.ExtOp     = ExtZero;
    bus.ALUCtrl   = '0;
    bus.illegal   = 1'b0;
    bus.bus_err   = timed_out;
    bus.state     = state_q;
    if (run_q) begin
      unique case (state_q)
        StFetch: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = SrcBFour;
          bus.ALUCtrl = ALUOP_W'(AluAdd);
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        StDecode: begin
          // Speculative branch target PC + (sext(imm) << 2).
          bus.ALUSrcB = SrcBImmSh2;
          bus.ExtOp   = ExtSign;
          bus.ALUCtrl = ALUOP_W'(AluAdd);
          bus.illegal = dec_illegal;
        end
        StExecR: begin
          bus.ALUSrcA = (dec_q.cls == ClsRShift) ? SrcAShamt : SrcARs;
          bus.ALUSrcB = SrcBRt;
          bus.ALUCtrl = ALUOP_W'(dec_q.aluop);
        end
        StExecI: begin
          bus.ALUSrcA = SrcARs;
          bus.ALUSrcB = SrcBImm;
          bus.ExtOp   = dec_q.extop;
          bus.ALUCtrl = ALUOP_W'(dec_q.aluop);
        end
        StMemAddr: begin
          bus.ALUSrcA = SrcARs;
          bus.ALUSrcB = SrcBImm;
          bus.ExtOp   = ExtSign;
          bus.ALUCtrl = ALUOP_W'(AluAdd);
        end
        StMemRd: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
        end
        StMemWr: begin
          bus.IorD     = 1'b1;
          bus.MemWrite = 1'b1;
        end
        StWbAlu: begin
          bus.RegWrite  = 1'b1;
          bus.DatatoReg = D2rAlu;
          bus.RegDst    = (dec_q.cls == ClsIArith) ? DstRt : DstRd;
        end
        StWbMem: begin
          bus.RegWrite  = 1'b1;
          bus.DatatoReg = D2rMem;
          bus.RegDst    = DstRt;
        end
        StBranch: begin
          bus.ALUSrcA = SrcARs;
          bus.ALUSrcB = SrcBRt;
          bus.ALUCtrl = ALUOP_W'(AluSub);
          bus.PC_sel  = PcBranch;
          bus.PCWrite = (dec_q.cls == ClsBne) ? ~bus.zero : bus.zero;
        end
        StJump: begin
          bus.PCWrite = 1'b1;
          bus.PC_sel  = (dec_q.cls == ClsJr) ? PcJr : PcJump;
          // Link value is the PC already advanced in FETCH.
          if (dec_q.cls == ClsJal) begin
            bus.RegWrite  = 1'b1;
            bus.RegDst    = DstRa;
            bus.DatatoReg = D2rPc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control words queued with stimulus.
module tb_mc_ctrl;

  localparam int unsigned AW = 5;

  // Expected encodings, written out independently of the design package.
  localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SExecR = 4'd2, SExecI = 4'd3;
  localparam logic [3:0] SMemAddr = 4'd4, SMemRd = 4'd5, SMemWr = 4'd6, SWbAlu = 4'd7;
  localparam logic [3:0] SWbMem = 4'd8, SBranch = 4'd9, SJump = 4'd10;
  localparam logic [4:0] AAdd = 5'd1, AAddu = 5'd3, AOr = 5'd6, ASll = 5'd8, ASub = 5'd2;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, mrd, mwr, irw, pcw;
    logic [1:0] pcsel, regdst;
    logic       regw;
    logic [1:0] d2r, srca, srcb;
    logic       ext;
    logic [4:0] alu;
    logic       ill, berr;
  } out_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks;
  int   n_errors;

  logic [1:0] stim_q[$];
  out_t       exp_q[$];

  always #5 clk = ~clk;

  mc_ctrl_if #(.ALUOP_W(AW)) bus ();

  mc_ctrl #(.ALUOP_W(AW), .MEM_TIMEOUT(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic out_t obs();
    out_t r;
    r.st = bus.state;  r.iord = bus.IorD;  r.mrd = bus.MemRead;  r.mwr = bus.MemWrite;
    r.irw = bus.IRWrite;  r.pcw = bus.PCWrite;  r.pcsel = bus.PC_sel;  r.regdst = bus.RegDst;
    r.regw = bus.RegWrite;  r.d2r = bus.DatatoReg;  r.srca = bus.ALUSrcA;
    r.srcb = bus.ALUSrcB;  r.ext = bus.ExtOp;  r.alu = bus.ALUCtrl;
    r.ill = bus.illegal;  r.berr = bus.bus_err;
    return r;
  endfunction

  function automatic out_t base(input logic [3:0] st);
    out_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic out_t e_fetch(input logic rdy, input logic err);
    out_t r;
    r = base(SFetch);  r.mrd = 1'b1;  r.srcb = 2'd1;  r.alu = AAdd;
    r.irw = rdy;  r.pcw = rdy;  r.berr = err;
    return r;
  endfunction

  function automatic out_t e_decode(input logic ill);
    out_t r;
    r = base(SDecode);  r.srcb = 2'd3;  r.ext = 1'b1;  r.alu = AAdd;  r.ill = ill;
    return r;
  endfunction

  function automatic out_t e_exec_r(input logic shamt, input logic [4:0] alu);
    out_t r;
    r = base(SExecR);  r.srca = shamt ? 2'd2 : 2'd1;  r.srcb = 2'd0;  r.alu = alu;
    return r;
  endfunction

  function automatic out_t e_exec_i(input logic ext, input logic [4:0] alu);
    out_t r;
    r = base(SExecI);  r.srca = 2'd1;  r.srcb = 2'd2;  r.ext = ext;  r.alu = alu;
    return r;
  endfunction

  function automatic out_t e_wb_alu(input logic [1:0] dst);
    out_t r;
    r = base(SWbAlu);  r.regw = 1'b1;  r.d2r = 2'd0;  r.regdst = dst;
    return r;
  endfunction

  function automatic out_t e_mem_addr();
    out_t r;
    r = base(SMemAddr);  r.srca = 2'd1;  r.srcb = 2'd2;  r.ext = 1'b1;  r.alu = AAdd;
    return r;
  endfunction

  function automatic out_t e_mem_rd();
    out_t r;
    r = base(SMemRd);  r.iord = 1'b1;  r.mrd = 1'b1;
    return r;
  endfunction

  function automatic out_t e_wb_mem();
    out_t r;
    r = base(SWbMem);  r.regw = 1'b1;  r.d2r = 2'd1;  r.regdst = 2'd0;
    return r;
  endfunction

  function automatic out_t e_mem_wr(input logic err);
    out_t r;
    r = base(SMemWr);  r.iord = 1'b1;  r.mwr = 1'b1;  r.berr = err;
    return r;
  endfunction

  function automatic out_t e_branch(input logic pcw);
    out_t r;
    r = base(SBranch);  r.srca = 2'd1;  r.srcb = 2'd0;  r.alu = ASub;
    r.pcsel = 2'd1;  r.pcw = pcw;
    return r;
  endfunction

  function automatic out_t e_jump(input logic [1:0] pcsel, input logic link);
    out_t r;
    r = base(SJump);  r.pcw = 1'b1;  r.pcsel = pcsel;
    if (link) begin
      r.regw = 1'b1;  r.regdst = 2'd2;  r.d2r = 2'd2;
    end
    return r;
  endfunction

  task automatic push(input logic mr, input logic z, input out_t e);
    stim_q.push_back({mr, z});
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.func   = fn;
  endtask

  // Apply queued stimulus one cycle at a time and compare mid-cycle.
  task automatic drain(input string name);
    int idx;
    logic [1:0] s;
    out_t e;
    idx = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      bus.mem_ready = s[1];
      bus.zero      = s[0];
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("%s.c%0d", name, idx), {4'b0, obs()}, {4'b0, e});
      idx++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_addu(input string name);
    load(6'h00, 6'h21);
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b0, e_exec_r(1'b0, AAddu));
    push(1'b1, 1'b0, e_wb_alu(2'd1));
    drain(name);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn = 1'b0;
    bus.opcode = 6'h3f;
    bus.func = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #12;
    check_eq("rst_idle", {4'b0, obs()}, {4'b0, base(SFetch)});
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    do_addu("addu");

    load(6'h00, 6'h00);  // sll uses shamt
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b0, e_exec_r(1'b1, ASll));
    push(1'b1, 1'b0, e_wb_alu(2'd1));
    drain("sll");

    load(6'h0d, 6'h00);  // ori zero-extends, two fetch wait cycles
    push(1'b0, 1'b0, e_fetch(1'b0, 1'b0));
    push(1'b0, 1'b0, e_fetch(1'b0, 1'b0));
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b0, e_exec_i(1'b0, AOr));
    push(1'b1, 1'b0, e_wb_alu(2'd0));
    drain("ori");

    load(6'h08, 6'h00);  // addi sign-extends
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b0, e_exec_i(1'b1, AAdd));
    push(1'b1, 1'b0, e_wb_alu(2'd0));
    drain("addi");

    load(6'h23, 6'h00);  // lw, three wait cycles
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b0, e_mem_addr());
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, e_mem_rd());
    push(1'b1, 1'b0, e_mem_rd());
    push(1'b0, 1'b0, e_wb_mem());
    drain("lw_wait3");

    load(6'h23, 6'h00);  // lw, ready exactly at the timeout limit
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b0, 1'b0, e_mem_addr());
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, e_mem_rd());
    push(1'b1, 1'b0, e_mem_rd());
    push(1'b0, 1'b0, e_wb_mem());
    drain("lw_limit");

    load(6'h04, 6'h00);  // beq, zero=0
    push(1'b1, 1'b1, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b1, e_decode(1'b0));
    push(1'b1, 1'b0, e_branch(1'b0));
    drain("beq_nz");

    load(6'h05, 6'h00);  // bne, zero=0
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b0, e_branch(1'b1));
    drain("bne_nz");

    load(6'h04, 6'h00);  // beq, zero=1
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b1, e_branch(1'b1));
    drain("beq_z");

    load(6'h03, 6'h00);
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b0, e_jump(2'd2, 1'b1));
    drain("jal");

    load(6'h02, 6'h00);
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b0, e_jump(2'd2, 1'b0));
    drain("j");

    load(6'h00, 6'h08);
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b1, 1'b0, e_jump(2'd3, 1'b0));
    drain("jr");

    load(6'h3f, 6'h00);  // illegal opcode returns straight to FETCH
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b1));
    drain("ill_op");

    load(6'h00, 6'h3f);  // illegal func
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b1));
    drain("ill_fn");

    load(6'h2b, 6'h00);  // sw, memory never answers
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b0, 1'b0, e_mem_addr());
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, e_mem_wr(1'b0));
    push(1'b0, 1'b0, e_mem_wr(1'b1));
    drain("sw_tmo");
    do_addu("after_sw_tmo");

    load(6'h00, 6'h21);  // fetch timeout, then a normal addu
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, e_fetch(1'b0, 1'b0));
    push(1'b0, 1'b0, e_fetch(1'b0, 1'b1));
    drain("fetch_tmo");
    do_addu("after_fetch_tmo");

    load(6'h2b, 6'h00);  // reset during MEM_WR
    push(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, e_decode(1'b0));
    push(1'b0, 1'b0, e_mem_addr());
    push(1'b0, 1'b0, e_mem_wr(1'b0));
    drain("sw_rst");
    #2;
    check_eq("sw_rst.pre", {4'b0, obs()}, {4'b0, e_mem_wr(1'b0)});
    rstn = 1'b0;
    #1;
    check_eq("sw_rst.abort", {4'b0, obs()}, {4'b0, base(SFetch)});
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    do_addu("after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
